// File: rtl/hwag_tooth_if.sv
`default_nettype none
// ============================================================================
// Module   : hwag_tooth_if
// Purpose  : Tooth input and angle/status outputs of the crank angle core.
// Revision : 1.0
// ============================================================================
interface hwag_tooth_if #(
    parameter int PCNT_WIDTH = 24
) ();
    logic                  cap;
    logic                  cap_edge_sel;
    logic                  sync;
    logic [5:0]            tooth;
    logic [11:0]           angle;
    logic                  tick;
    logic                  gap;
    logic                  err;
    logic [PCNT_WIDTH-1:0] period;

    modport master (
        output cap, cap_edge_sel,
        input  sync, tooth, angle, tick, gap, err, period
    );

    modport slave (
        input  cap, cap_edge_sel,
        output sync, tooth, angle, tick, gap, err, period
    );
endinterface
`default_nettype wire

// File: rtl/hwag_tooth_core.sv
`default_nettype none
// ============================================================================
// Module   : hwag_tooth_core
// Purpose  : 60-2 crank wheel edge capture, gap sync and angle interpolation.
//            Optional input majority filter: define HWAG_CAP_FILTER_EN.
// Revision : 1.0
// ============================================================================
module hwag_tooth_core #(
    parameter int PCNT_WIDTH    = 24,
    parameter int TICK_SHIFT    = 6,
    parameter int TEETH_REAL    = 58,
    parameter int TEETH_MISSING = 2
) (
    input wire          clk,
    input wire          rst,
    hwag_tooth_if.slave bus
);

    localparam int                    SUB_W        = $clog2((TEETH_MISSING + 1) << TICK_SHIFT);
    localparam logic [SUB_W-1:0]      SUB_MAX_NORM = SUB_W'((1 << TICK_SHIFT) - 1);
    localparam logic [SUB_W-1:0]      SUB_MAX_GAP  = SUB_W'(((TEETH_MISSING + 1) << TICK_SHIFT) - 1);
    localparam logic [5:0]            LAST_TOOTH   = 6'(TEETH_REAL - 1);
    localparam logic [PCNT_WIDTH-1:0] PCNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        SYNC = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning and edge detection
    // ------------------------------------------------------------------
    logic r_s1, r_s2, r_s3;
    logic w_cap_clean;
    logic w_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.cap;
            r_s2 <= r_s1;
        end
    end

`ifdef HWAG_CAP_FILTER_EN
    logic r_f1, r_f2, r_filt;

    // 3-sample majority: a level must persist two clocks to pass
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f1   <= 1'b0;
            r_f2   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_f1   <= r_s2;
            r_f2   <= r_f1;
            r_filt <= (r_s2 & r_f1) | (r_s2 & r_f2) | (r_f1 & r_f2);
        end
    end

    assign w_cap_clean = r_filt;
`else
    assign w_cap_clean = r_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_s3 <= 1'b0;
        else      r_s3 <= w_cap_clean;
    end

    assign w_edge = bus.cap_edge_sel ? (w_cap_clean & ~r_s3) : (~w_cap_clean & r_s3);

    // ------------------------------------------------------------------
    // Period measurement and gap test
    // ------------------------------------------------------------------
    logic [PCNT_WIDTH-1:0] r_pcnt, r_cur;
    logic [PCNT_WIDTH-1:0] w_cur_nxt;
    logic [PCNT_WIDTH:0]   w_prev_ext, w_gap_thresh;
    logic                  w_is_gap;
    logic                  w_stall;

    assign w_cur_nxt = (r_pcnt == PCNT_MAX) ? PCNT_MAX : r_pcnt + PCNT_WIDTH'(1);

    // r_cur is the period that becomes "prev" on this edge
    assign w_prev_ext   = {1'b0, r_cur};
    assign w_gap_thresh = w_prev_ext + (w_prev_ext >> 1);
    assign w_is_gap     = (r_cur != '0) && ({1'b0, w_cur_nxt} > w_gap_thresh);
    assign w_stall      = (r_pcnt == PCNT_MAX) && !w_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
            r_cur  <= '0;
        end else if (w_edge) begin
            r_pcnt <= '0;
            r_cur  <= w_cur_nxt;
        end else if (r_pcnt != PCNT_MAX) begin
            r_pcnt <= r_pcnt + PCNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sync state machine and tick interpolation
    // ------------------------------------------------------------------
    state_t                r_state, w_state_nxt;
    logic [5:0]            r_tooth, w_tooth_nxt;
    logic [SUB_W-1:0]      r_subtick, w_subtick_nxt;
    logic [PCNT_WIDTH-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [PCNT_WIDTH-1:0] r_tick_period, w_tick_period_nxt;
    logic [PCNT_WIDTH-1:0] r_period, w_period_nxt;
    logic [PCNT_WIDTH-1:0] w_tp_raw;
    logic [SUB_W-1:0]      w_sub_limit;
    logic [11:0]           r_angle, w_angle_nxt;
    logic                  r_tick, r_gap, r_err;
    logic                  w_tick_nxt, w_gap_nxt, w_err_nxt;

    assign w_tp_raw    = w_cur_nxt >> TICK_SHIFT;
    assign w_sub_limit = (r_tooth == LAST_TOOTH) ? SUB_MAX_GAP : SUB_MAX_NORM;

    always_comb begin
        w_state_nxt       = r_state;
        w_tooth_nxt       = r_tooth;
        w_subtick_nxt     = r_subtick;
        w_tick_cnt_nxt    = r_tick_cnt;
        w_tick_period_nxt = r_tick_period;
        w_period_nxt      = r_period;
        w_tick_nxt        = 1'b0;
        w_gap_nxt         = 1'b0;
        w_err_nxt         = 1'b0;

        if (w_edge) begin
            // An edge always wins over a coincident tick terminal count
            w_tick_cnt_nxt = '0;
            w_subtick_nxt  = '0;
            if (!w_is_gap && (r_state != IDLE)) begin
                w_period_nxt      = w_cur_nxt;
                w_tick_period_nxt = (w_tp_raw == '0) ? PCNT_WIDTH'(1) : w_tp_raw;
            end
            case (r_state)
                IDLE: w_state_nxt = SEEK;
                SEEK: begin
                    if (w_is_gap) begin
                        w_state_nxt = SYNC;
                        w_tooth_nxt = '0;
                        w_gap_nxt   = 1'b1;
                    end
                end
                SYNC: begin
                    if (w_is_gap == (r_tooth == LAST_TOOTH)) begin
                        w_tooth_nxt = w_is_gap ? 6'd0 : r_tooth + 6'd1;
                        w_gap_nxt   = w_is_gap;
                    end else begin
                        // early gap or missing gap
                        w_state_nxt = SEEK;
                        w_tooth_nxt = '0;
                        w_err_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (w_stall) begin
            w_state_nxt    = IDLE;
            w_tooth_nxt    = '0;
            w_subtick_nxt  = '0;
            w_tick_cnt_nxt = '0;
            w_err_nxt      = (r_state == SYNC);
        end else if (r_state == SYNC) begin
            if (r_tick_cnt == r_tick_period - PCNT_WIDTH'(1)) begin
                w_tick_cnt_nxt = '0;
                if (r_subtick < w_sub_limit) begin
                    w_subtick_nxt = r_subtick + SUB_W'(1);
                    w_tick_nxt    = 1'b1;
                end
            end else begin
                w_tick_cnt_nxt = r_tick_cnt + PCNT_WIDTH'(1);
            end
        end

        w_angle_nxt = (w_state_nxt == SYNC)
                    ? (({6'd0, w_tooth_nxt} << TICK_SHIFT) + 12'(w_subtick_nxt))
                    : 12'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_tooth       <= '0;
            r_subtick     <= '0;
            r_tick_cnt    <= '0;
            r_tick_period <= '0;
            r_period      <= '0;
            r_angle       <= '0;
            r_tick        <= 1'b0;
            r_gap         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tooth       <= w_tooth_nxt;
            r_subtick     <= w_subtick_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_tick_period <= w_tick_period_nxt;
            r_period      <= w_period_nxt;
            r_angle       <= w_angle_nxt;
            r_tick        <= w_tick_nxt;
            r_gap         <= w_gap_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign bus.sync   = (r_state == SYNC);
    assign bus.tooth  = r_tooth;
    assign bus.angle  = r_angle;
    assign bus.tick   = r_tick;
    assign bus.gap    = r_gap;
    assign bus.err    = r_err;
    assign bus.period = r_period;

endmodule
`default_nettype wire

// File: tb/tb_hwag_tooth_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_tooth_core
// Purpose  : Scoreboard bench: directed 60-2 wheel stimulus, event monitor.
// Revision : 1.0
// ============================================================================
module tb_hwag_tooth_core;

    localparam int PW    = 12;   // small counter so a stall is reachable quickly
    localparam int T     = 128;  // normal tooth period, 2 clk per angle tick
    localparam int TG    = 3 * T;
    localparam int HIGH  = 32;   // fixed high time keeps falling edges evenly spaced
    localparam int CLK_P = 10;

    typedef struct {
        bit is_gap;
        int period;
        int ticks;
        int prev_angle;
    } ev_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    hwag_tooth_if #(.PCNT_WIDTH(PW)) bus ();

    hwag_tooth_core #(
        .PCNT_WIDTH   (PW),
        .TICK_SHIFT   (6),
        .TEETH_REAL   (58),
        .TEETH_MISSING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic teeth(input int n, input int len);
        for (int i = 0; i < n; i++) begin
            bus.cap = 1'b1;
            cyc(HIGH);
            bus.cap = 1'b0;
            cyc(len - HIGH);
        end
    endtask

    task automatic push(input bit is_gap, input int ticks, input int prev_angle);
        ev_t e;
        e.is_gap     = is_gap;
        e.period     = T;
        e.ticks      = ticks;
        e.prev_angle = prev_angle;
        exp_q.push_back(e);
    endtask

    // Monitor: every gap/err pulse pops one expected event
    initial begin : monitor
        ev_t e;
        int  tick_seen;
        int  last_angle;
        tick_seen  = 0;
        last_angle = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tick_seen  = 0;
                last_angle = 0;
            end else begin
                if (bus.gap || bus.err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", int'(bus.gap) + int'(bus.err), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_gap",    int'(bus.gap),    int'(e.is_gap));
                        check("event_err",    int'(bus.err),    int'(!e.is_gap));
                        check("event_sync",   int'(bus.sync),   int'(e.is_gap));
                        check("event_angle",  int'(bus.angle),  0);
                        check("event_period", int'(bus.period), e.period);
                        if (e.is_gap)
                            check("gap_tooth", int'(bus.tooth), 0);
                        check("event_ticks", tick_seen, e.ticks);
                        check("event_prev_angle", last_angle, e.prev_angle);
                    end
                    tick_seen = 0;
                end
                if (bus.tick) tick_seen++;
                last_angle = int'(bus.angle);
            end
        end
    end

    initial begin : watchdog
        #(CLK_P * 80000);
        $display("FAIL watchdog: time limit reached with %0d events pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst              = 1'b0;
        bus.cap          = 1'b0;
        bus.cap_edge_sel = 1'b1;

        // Reset held while the input toggles
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            bus.cap = ~bus.cap;
        end
        @(negedge clk);
        check("rst_sync",   int'(bus.sync),   0);
        check("rst_tooth",  int'(bus.tooth),  0);
        check("rst_angle",  int'(bus.angle),  0);
        check("rst_tick",   int'(bus.tick),   0);
        check("rst_gap",    int'(bus.gap),    0);
        check("rst_err",    int'(bus.err),    0);
        check("rst_period", int'(bus.period), 0);
        bus.cap = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(150);
        @(negedge clk);
        check("presync_sync", int'(bus.sync), 0);

        // Lock on rising edges, then one full revolution
        teeth(5, T);
        teeth(1, TG);
        push(1'b1, 0, 0);
        teeth(57, T);
        teeth(1, TG);
        push(1'b1, 57 * 63 + 191, 57 * 64 + 191);

        // Early gap at tooth 20, relock at the true gap
        teeth(20, T);
        teeth(1, TG);
        push(1'b0, 21 * 63, 20 * 64 + 63);
        teeth(36, T);
        teeth(1, TG);
        push(1'b1, 0, 0);
        teeth(57, T);
        teeth(1, TG);
        push(1'b1, 57 * 63 + 191, 57 * 64 + 191);

        // Missing gap after tooth 57
        teeth(58, T);
        push(1'b0, 58 * 63, 57 * 64 + 63);
        teeth(3, T);
        teeth(1, TG);

        // Relock, then stop the wheel: stall while synced
        push(1'b1, 0, 0);
        teeth(1, T);
        push(1'b0, 63, 63);
        cyc(4300);
        @(negedge clk);
        check("stall_sync",  int'(bus.sync),  0);
        check("stall_angle", int'(bus.angle), 0);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_period", int'(bus.period), 0);
        check("async_rst_sync",   int'(bus.sync),   0);
        check("async_rst_tooth",  int'(bus.tooth),  0);

        // Same wheel on falling edges
        bus.cap_edge_sel = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(150);
        teeth(5, T);
        teeth(1, TG);
        push(1'b1, 0, 0);
        teeth(57, T);
        teeth(1, TG);
        push(1'b1, 57 * 63 + 191, 57 * 64 + 191);
        teeth(1, T);
        cyc(20);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("events_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwag_tooth_core.md
Name: hwag_tooth_core

Overview:
Hardware angle generator core for a 60-2 crank trigger wheel (58 real teeth, 2 missing). It captures tooth edges from a conditioned VR/Hall input and measures the tooth period in clock cycles. It locates the missing-tooth gap and synchronises a tooth counter to it. It then interpolates a fixed number of angle ticks per tooth, producing a continuous crank angle for downstream ignition/injection schedulers and the diagnostic DAC.

Parameters:
PCNT_WIDTH, 24, width of period counter and period registers
TICK_SHIFT, 6, log2 of angle ticks per tooth (64 ticks per tooth)
TEETH_REAL, 58, physical teeth per revolution
TEETH_MISSING, 2, missing teeth forming the gap

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
cap  input  1  raw tooth signal, asynchronous to clk
cap_edge_sel  input  1  active edge select: 1 = rising, 0 = falling
sync  output  1  high while locked to the wheel
tooth  output  6  current tooth index, 0..TEETH_REAL-1
angle  output  12  tooth*64 + subtick, range 0..3839
tick  output  1  one-clk pulse per angle tick
gap  output  1  one-clk pulse on an accepted gap edge
err  output  1  one-clk pulse on sync loss (early, late or stall)
period  output  PCNT_WIDTH  last normal-tooth period in clk cycles

Behaviour:
- Reset (rst=0), asynchronous: all registers are 0, state = IDLE, and all outputs are 0.
- cap passes through a 2-flop synchroniser and then an edge register. An edge pulse occurs when the synchronised value transitions in the direction chosen by cap_edge_sel. Latency is 3 clk from cap change to the internal edge. cap_edge_sel is sampled each clk; changing it mid-run may cause one missed or extra edge, and that is acceptable.
- Period counter pcnt increments every clk and saturates at all-ones. On an edge: cur <= pcnt+1, prev <= cur, then pcnt <= 0.
- Gap test on an edge, with cur being the new value: prev != 0 and cur > prev + (prev>>1).
- States:
  - IDLE: first edge moves to SEEK.
  - SEEK: an edge with gap true moves to SYNC, sets tooth = 0 and pulses gap.
  - SYNC: tooth increments on each non-gap edge. When tooth == TEETH_REAL-1, the next edge must be a gap; it pulses gap and sets tooth = 0.
- Sync loss, each of which pulses err, clears sync, and moves to SEEK:
  - a gap edge while tooth < TEETH_REAL-1 (early gap);
  - a non-gap edge while tooth == TEETH_REAL-1 (missing gap).
- Stall: pcnt saturating in any state moves to IDLE and pulses err if in SYNC.
- sync = (state == SYNC).
- Tick interpolation runs only in SYNC:
  - On each non-gap edge in SYNC or SEEK: period <= cur and tick_period <= max(1, cur >> TICK_SHIFT).
  - On gap edges, period and tick_period are left unchanged.
  - tick_cnt counts clocks and resets on every edge. When it reaches tick_period-1, tick pulses and subtick increments.
- subtick limits:
  - Normal tooth: saturates at 63, with no tick pulses while saturated.
  - Tooth TEETH_REAL-1 (gap tooth): limit is (TEETH_MISSING+1)*64-1 = 191.
  - Any edge resets subtick to 0.
- angle = tooth*64 + subtick, registered; 0 outside SYNC.
- An edge and a tick terminal count in the same clk: the edge wins, subtick = 0 and no tick pulse.

Optional Feature:
HWAG_CAP_FILTER_EN
- Defined: a 3-sample majority filter follows the synchroniser, adding 2 clk latency (5 total). Single-clk glitches on cap produce no edge.
- Undefined: no filter, 3-clk latency, and glitches of 1 clk or more after synchronisation are seen as edges.

Test Plan:
- Reset: hold rst=0 with cap toggling → all outputs 0. Release → sync=0 until the first gap is seen.
- Lock: 60-2 wheel, tooth period 4096 clk, rising edges with cap_edge_sel=1, gap period 12288 → gap pulses, sync=1, tooth=0; after the next tooth, period=4096.
- Interpolation: in SYNC at 4096 clk/tooth → one tick every 64 clk; angle runs 0..63 per tooth and reaches 3839 at end of gap; tooth wraps 57→0.
- Early gap: insert a 3×period tooth at tooth 20 → err pulse, sync=0; relock at the next true gap.
- Missing gap: a normal edge after tooth 57 → err, sync=0. Stop cap entirely → stall; state IDLE once pcnt saturates.
- Edge select: cap_edge_sel=0 with the same stimulus → lock on falling edges, same period values.
